// File: rtl/flash_read_arbiter.sv
// flash_read_arbiter: round-robin arbiter sharing one flash Avalon-MM read port
// between two requesters, one read in flight, with a lost-readdatavalid timeout.
module flash_read_arbiter #(
   parameter int ADDR_W = 23,
   parameter int DATA_W = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rq0_read,
   input  logic [ADDR_W-1:0] rq0_address,
   output logic              rq0_waitrequest,
   output logic [DATA_W-1:0] rq0_readdata,
   output logic              rq0_readdatavalid,
   input  logic              rq1_read,
   input  logic [ADDR_W-1:0] rq1_address,
   output logic              rq1_waitrequest,
   output logic [DATA_W-1:0] rq1_readdata,
   output logic              rq1_readdatavalid,
   output logic              flash_mem_read,
   output logic [ADDR_W-1:0] flash_mem_address,
   output logic [3:0]        flash_mem_byteenable,
   input  logic              flash_mem_waitrequest,
   input  logic [DATA_W-1:0] flash_mem_readdata,
   input  logic              flash_mem_readdatavalid,
   output logic              busy,
   output logic              timeout_err
);
   localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT_DATA = 2'd2;
   localparam int CNT_W = $clog2(TIMEOUT);
   logic [1:0]        state;
   logic [CNT_W-1:0]  cnt;
   logic              last_grant, owner, gnt0, gnt1, done;
   logic [DATA_W-1:0] ret_data;
   // a grant is only ever raised for a requester that is actually asking
   assign gnt0 = state == IDLE && rq0_read && (!rq1_read || last_grant);
   assign gnt1 = state == IDLE && rq1_read && (!rq0_read || !last_grant);
   assign rq0_waitrequest = ~gnt0;
   assign rq1_waitrequest = ~gnt1;
   assign done = state == WAIT_DATA && (flash_mem_readdatavalid || cnt == CNT_W'(TIMEOUT - 1));
   assign ret_data = flash_mem_readdatavalid ? flash_mem_readdata : '0;
   assign busy = state != IDLE;
   assign flash_mem_byteenable = 4'b1111;
   always_ff @(posedge clk) begin
      if (reset) begin
         state             <= IDLE;
         cnt               <= '0;
         last_grant        <= 1'b1;
         owner             <= 1'b0;
         flash_mem_read    <= 1'b0;
         flash_mem_address <= '0;
         rq0_readdata      <= '0;
         rq1_readdata      <= '0;
         rq0_readdatavalid <= 1'b0;
         rq1_readdatavalid <= 1'b0;
         timeout_err       <= 1'b0;
      end else begin
         rq0_readdatavalid <= done && !owner;
         rq1_readdatavalid <= done && owner;
         if (done && !owner) rq0_readdata <= ret_data;
         if (done && owner) rq1_readdata <= ret_data;
         if (done && !flash_mem_readdatavalid) timeout_err <= 1'b1;
         if (gnt0 || gnt1) begin
            flash_mem_address <= gnt1 ? rq1_address : rq0_address;
            owner             <= gnt1;
            last_grant        <= gnt1;
            flash_mem_read    <= 1'b1;
            state             <= ISSUE;
         end else if (state == ISSUE && !flash_mem_waitrequest) begin
            flash_mem_read <= 1'b0;
            cnt            <= '0;
            state          <= WAIT_DATA;
         end else if (done || state == 2'd3) begin
            state <= IDLE;
         end else if (state == WAIT_DATA) begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end
endmodule
